tage_ghr_ckpt: RTL and testbench

- Speculative global-history manager feeding the TAGE predictor.
- Shifts predicted directions of conditional branches into a speculative GHR, which drives the predictor's predict history input.
- Keeps a circular checkpoint queue of pre-branch history per in-flight branch.
- Repairs the GHR on mispredict flush, and emits one registered, in-order update record per committed branch for the predictor's update port.

---
 rtl/tage_ghr_ckpt.sv | 146 ++++++++++++++
 tb/tb_tage_ghr_ckpt.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/tage_ghr_ckpt.sv
// Speculative TAGE global-history register with a circular per-branch checkpoint queue,
// flush repair and in-order registered predictor-update records. Optional perf counters: TAGE_GHR_PERF_EN.
module tage_ghr_ckpt #(
    parameter int GHR_BITS   = 8,
    parameter int CKPT_DEPTH = 8,
    parameter int PLEN       = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          spec_valid_i,
    input  logic                          spec_taken_i,
    input  logic [PLEN-1:0]               spec_pc_i,
    output logic [GHR_BITS-1:0]           ghr_o,
    output logic [$clog2(CKPT_DEPTH)-1:0] spec_id_o,
    output logic                          full_o,
    output logic                          empty_o,
    input  logic                          flush_valid_i,
    input  logic [$clog2(CKPT_DEPTH)-1:0] flush_id_i,
    input  logic                          flush_taken_i,
    input  logic                          commit_valid_i,
    input  logic                          commit_taken_i,
`ifdef TAGE_GHR_PERF_EN
    output logic [31:0]                   perf_flush_cnt_o,
    output logic [31:0]                   perf_full_drop_cnt_o,
`endif
    output logic                          update_valid_o,
    output logic [PLEN-1:0]               update_pc_o,
    output logic [GHR_BITS-1:0]           update_ghr_o,
    output logic                          update_taken_o
);

    localparam int IDW = $clog2(CKPT_DEPTH);

    logic [GHR_BITS-1:0] ghr_q, ghr_d;
    logic [IDW:0]        head_q, head_d, tail_q, tail_d;
    logic [PLEN-1:0]     ckpt_pc_q  [CKPT_DEPTH];
    logic [GHR_BITS-1:0] ckpt_ghr_q [CKPT_DEPTH];

    logic                upd_vld_q;
    logic [PLEN-1:0]     upd_pc_q;
    logic [GHR_BITS-1:0] upd_ghr_q;
    logic                upd_tk_q;

    logic         full, empty, commit_fire, push_en;
    logic [IDW:0] flush_pos, occupancy;
    logic [IDW-1:0] flush_ofs;
    logic         flush_alloc;

    // Concatenate-then-truncate keeps the shift legal for GHR_BITS == 1.
    function automatic logic [GHR_BITS-1:0] shift_in(input logic [GHR_BITS-1:0] h, input logic t);
        logic [GHR_BITS:0] tmp;
        tmp = {h, t};
        return tmp[GHR_BITS-1:0];
    endfunction

    assign full        = (head_q[IDW-1:0] == tail_q[IDW-1:0]) && (head_q[IDW] != tail_q[IDW]);
    assign empty       = (head_q == tail_q);
    assign commit_fire = commit_valid_i && !empty;
    assign push_en     = spec_valid_i && !flush_valid_i && (!full || commit_fire);

    // Ids below the head index have wrapped past the end of the RAM relative to head.
    assign flush_pos   = {(flush_id_i >= head_q[IDW-1:0]) ? head_q[IDW] : ~head_q[IDW], flush_id_i};
    assign flush_ofs   = flush_id_i - head_q[IDW-1:0];
    assign occupancy   = tail_q - head_q;
    assign flush_alloc = ({1'b0, flush_ofs} < occupancy);

    always_comb begin
        ghr_d  = ghr_q;
        tail_d = tail_q;
        head_d = head_q;
        if (flush_valid_i) begin
            ghr_d  = shift_in(ckpt_ghr_q[flush_id_i], flush_taken_i);
            tail_d = flush_pos + 1'b1;
        end else if (push_en) begin
            ghr_d  = shift_in(ghr_q, spec_taken_i);
            tail_d = tail_q + 1'b1;
        end
        if (commit_fire) begin
            head_d = head_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ghr_q     <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            upd_vld_q <= 1'b0;
            upd_pc_q  <= '0;
            upd_ghr_q <= '0;
            upd_tk_q  <= 1'b0;
        end else begin
            ghr_q     <= ghr_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            upd_vld_q <= commit_fire;
            if (commit_fire) begin
                upd_pc_q  <= ckpt_pc_q[head_q[IDW-1:0]];
                upd_ghr_q <= ckpt_ghr_q[head_q[IDW-1:0]];
                upd_tk_q  <= commit_taken_i;
            end
        end
    end

    // Checkpoint RAM carries no reset; validity is defined by head/tail alone.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push_en) begin
            ckpt_pc_q[tail_q[IDW-1:0]]  <= spec_pc_i;
            ckpt_ghr_q[tail_q[IDW-1:0]] <= ghr_q;
        end
    end

`ifdef TAGE_GHR_PERF_EN
    logic [31:0] perf_flush_q, perf_drop_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_flush_q <= '0;
            perf_drop_q  <= '0;
        end else begin
            if (flush_valid_i && perf_flush_q != 32'hFFFF_FFFF) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
            if (spec_valid_i && full && !commit_fire && perf_drop_q != 32'hFFFF_FFFF) begin
                perf_drop_q <= perf_drop_q + 32'd1;
            end
        end
    end

    assign perf_flush_cnt_o     = perf_flush_q;
    assign perf_full_drop_cnt_o = perf_drop_q;
`endif

    flush_id_allocated: assert property (@(posedge clk_i) disable iff (rst_i)
        flush_valid_i |-> flush_alloc);

    assign ghr_o          = ghr_q;
    assign spec_id_o      = tail_q[IDW-1:0];
    assign full_o         = full;
    assign empty_o        = empty;
    assign update_valid_o = upd_vld_q;
    assign update_pc_o    = upd_pc_q;
    assign update_ghr_o   = upd_ghr_q;
    assign update_taken_o = upd_tk_q;

endmodule

// File: tb/tb_tage_ghr_ckpt.sv
// Directed plus randomized bench for tage_ghr_ckpt against a queue-level reference model.
module tb_tage_ghr_ckpt;

    localparam int GB = 8;
    localparam int D  = 8;

    logic        clk_i = 1'b0;
    logic        rst_i, spec_valid_i, spec_taken_i, flush_valid_i, flush_taken_i;
    logic        commit_valid_i, commit_taken_i;
    logic [31:0] spec_pc_i;
    logic [2:0]  flush_id_i;
    logic [GB-1:0] ghr_o, update_ghr_o;
    logic [2:0]  spec_id_o;
    logic        full_o, empty_o, update_valid_o, update_taken_o;
    logic [31:0] update_pc_o;
`ifdef TAGE_GHR_PERF_EN
    logic [31:0] perf_flush_cnt_o, perf_full_drop_cnt_o;
`endif

    tage_ghr_ckpt #(.GHR_BITS(GB), .CKPT_DEPTH(D), .PLEN(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .spec_valid_i(spec_valid_i), .spec_taken_i(spec_taken_i), .spec_pc_i(spec_pc_i),
        .ghr_o(ghr_o), .spec_id_o(spec_id_o), .full_o(full_o), .empty_o(empty_o),
        .flush_valid_i(flush_valid_i), .flush_id_i(flush_id_i), .flush_taken_i(flush_taken_i),
        .commit_valid_i(commit_valid_i), .commit_taken_i(commit_taken_i),
`ifdef TAGE_GHR_PERF_EN
        .perf_flush_cnt_o(perf_flush_cnt_o), .perf_full_drop_cnt_o(perf_full_drop_cnt_o),
`endif
        .update_valid_o(update_valid_o), .update_pc_o(update_pc_o),
        .update_ghr_o(update_ghr_o), .update_taken_o(update_taken_o)
    );

    always #5 clk_i = ~clk_i;

    int ntests = 0;
    int nfail  = 0;

    // Reference model: absolute branch sequence numbers, ids are sequence mod D.
    int          m_ghr, m_head, m_tail;
    int          m_pc  [D];
    int          m_hist[D];
    int          m_uv, m_upc, m_ughr, m_utk;
    longint      m_pflush, m_pdrop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ghr = 0; m_head = 0; m_tail = 0;
        m_uv = 0; m_upc = 0; m_ughr = 0; m_utk = 0;
        m_pflush = 0; m_pdrop = 0;
    endtask

    function automatic int hist_in(input int h, input int t);
        return ((h << 1) | t) & ((1 << GB) - 1);
    endfunction

    task automatic step(input bit rst, input bit sv, input bit st, input logic [31:0] pc,
                        input bit fv, input int fid, input bit ft,
                        input bit cv, input bit ct, input bit do_chk);
        int cnt, k;
        bit cfire;
        rst_i = rst; spec_valid_i = sv; spec_taken_i = st; spec_pc_i = pc;
        flush_valid_i = fv; flush_id_i = 3'(fid); flush_taken_i = ft;
        commit_valid_i = cv; commit_taken_i = ct;
        @(negedge clk_i);
        cnt = m_tail - m_head;
        if (do_chk) begin
            chk("ghr", 32'(ghr_o), m_ghr);
            chk("spec_id", 32'(spec_id_o), m_tail % D);
            chk("full", 32'(full_o), (cnt == D) ? 1 : 0);
            chk("empty", 32'(empty_o), (cnt == 0) ? 1 : 0);
            chk("upd_vld", 32'(update_valid_o), m_uv);
            chk("upd_pc", update_pc_o, m_upc);
            chk("upd_ghr", 32'(update_ghr_o), m_ughr);
            chk("upd_tk", 32'(update_taken_o), m_utk);
`ifdef TAGE_GHR_PERF_EN
            chk("perf_flush", perf_flush_cnt_o, 32'(m_pflush));
            chk("perf_drop", perf_full_drop_cnt_o, 32'(m_pdrop));
`endif
        end
        if (rst) begin
            model_reset();
        end else begin
            cfire = cv && (cnt != 0);
            m_uv = cfire;
            if (cfire) begin
                m_upc = m_pc[m_head % D]; m_ughr = m_hist[m_head % D]; m_utk = ct;
            end
            if (fv) m_pflush++;
            if (sv && cnt == D && !cfire) m_pdrop++;
            if (fv) begin
                for (k = 0; k < cnt; k++) if ((m_head + k) % D == fid) break;
                m_ghr  = hist_in(m_hist[fid], ft);
                m_tail = m_head + k + 1;
            end else if (sv && (cnt < D || cfire)) begin
                m_pc[m_tail % D] = pc; m_hist[m_tail % D] = m_ghr;
                m_ghr = hist_in(m_ghr, st);
                m_tail++;
            end
            if (cfire) m_head++;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic push(input bit t, input logic [31:0] pc);
        step(0, 1, t, pc, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        int cnt, fid;
        bit sv, fv, cv, rs;
        model_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();

        // Three speculative pushes: T, T, NT.
        push(1, 32'h8000_0000); chk("ghr_after_T", 32'(ghr_o), 32'h01);
        push(1, 32'h8000_0004); chk("ghr_after_TT", 32'(ghr_o), 32'h03);
        push(0, 32'h8000_0008); chk("ghr_after_TTN", 32'(ghr_o), 32'h06);
        chk("not_empty", 32'(empty_o), 0);

        // Fill to 8, then a dropped 9th push.
        for (int i = 3; i < 8; i++) push(i[0], 32'h8000_0000 + 32'(i * 4));
        chk("full_at_8", 32'(full_o), 1);
        push(1, 32'h8000_0020);
        idle();

        // Flush repair after T,T,T.
        do_reset();
        push(1, 32'h8000_0000); push(1, 32'h8000_0004); push(1, 32'h8000_0008);
        chk("ghr_TTT", 32'(ghr_o), 32'h07);
        step(0, 1, 1, 32'h8000_000C, 1, 1, 0, 0, 0, 1);
        chk("ghr_flush", 32'(ghr_o), 32'h02);
        chk("id_flush", 32'(spec_id_o), 2);
        idle();

        // Commit of the oldest branch produces exactly one update record.
        do_reset();
        push(1, 32'h8000_0000);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        chk("commit_vld", 32'(update_valid_o), 1);
        chk("commit_pc", update_pc_o, 32'h8000_0000);
        idle();
        chk("commit_vld_drop", 32'(update_valid_o), 0);

        // Commit and flush of the single head entry in one cycle.
        do_reset();
        push(0, 32'h8000_0100);
        push(1, 32'h8000_0104);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 1, 1, 1, 1, 1, 1);
        chk("cf_empty", 32'(empty_o), 1);
        idle(); idle();

        // Push/commit 20 branches across the pointer wrap, then reset mid-stream.
        do_reset();
        push(1, 32'h9000_0000);
        for (int i = 1; i <= 20; i++) step(0, 1, i[1], 32'h9000_0000 + 32'(i * 4), 0, 0, 0, 1, i[0], 1);
        step(0, 1, 1, 32'h9000_1000, 0, 0, 0, 1, 1, 1);
        do_reset();
        chk("rst_ghr", 32'(ghr_o), 0);
        chk("rst_empty", 32'(empty_o), 1);
        chk("rst_upd_vld", 32'(update_valid_o), 0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            cnt = m_tail - m_head;
            fv  = (cnt > 0) && ($urandom_range(0, 99) < 8);
            fid = (cnt > 0) ? (m_head + int'($urandom_range(0, cnt - 1))) % D : 0;
            sv  = $urandom_range(0, 99) < 60;
            cv  = $urandom_range(0, 99) < ((cnt > 0) ? 40 : 10);
            rs  = $urandom_range(0, 999) < 5;
            step(rs, sv, 1'($urandom), $urandom, fv, fid, 1'($urandom), cv, 1'($urandom), 1);
        end

        do_reset();
        idle();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
